am2940_dma_sequencer: RTL and testbench
=======================================

Name: am2940_dma_sequencer

Overview:
- Controls the Am2940 DMA address generator datapath: produces the 3-bit instruction I[2:0] and the DATA-bus write values that the instruction decoder consumes.
- Per transfer: programs the control register, address and word count, then issues one ENCT per beat under a DREQ/DACK handshake with the peripheral.
- Detects end of transfer, raises a completion interrupt and, optionally, re-initialises for autoload.
- Sits between the CPU configuration registers and the address generator / instruction decoder.

Parameters:
- W, 8: width of the address, word count and DATA bus.

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to begin a transfer; accepted only in IDLE
- abort  in  1  terminates the transfer; highest priority after reset
- cfg_cr  in  3  control word for WRCR; [1:0] mode, [2] address decrement
- cfg_addr  in  W  start address for LDAD
- cfg_count  in  W  word count for LDWC; also the internal beat limit in mode 2
- cfg_auto  in  1  when 1, REIN after completion instead of returning to IDLE
- dreq  in  1  peripheral beat request, level-sensitive
- done  in  1  generator word-count terminal flag; ignored in mode 2
- I  out  3  instruction to the address generator / decoder
- data_out  out  W  value driven onto DATA during WRCR/LDAD/LDWC
- data_oe  out  1  sequencer drives DATA
- dack  out  1  beat acknowledge, one cycle per ENCT
- busy  out  1  high in every state except IDLE
- irq_done  out  1  one-cycle completion pulse
- aborted  out  1  one-cycle pulse when abort ends a transfer

Behaviour:
- All outputs are registered. Reset values: I=3'b001 (RDCR, no state change), data_out=0, data_oe=0, dack=0, busy=0, irq_done=0, aborted=0, state=IDLE, beat counter=0.
- Instruction encoding: WRCR=000, RDCR=001, LDAD=101, LDWC=110, REIN=100, ENCT=111. Whenever no other instruction is specified, I=001.
- States: IDLE, WRCR, LDAD, LDWC, ACTIVE, XFER, FINISH, REIN.
- IDLE:
  - start=1 captures cfg_* into shadow registers and moves to WRCR.
  - cfg_* changes after capture have no effect until the next start.
- WRCR, LDAD, LDWC:
  - Each lasts exactly one cycle, in that order.
  - I = 000 / 101 / 110; data_out = shadow CR (zero-extended) / addr / count; data_oe=1.
  - Start-to-first-possible-ENCT latency: 4 cycles plus dreq sampling.
- ACTIVE: I=001, dack=0.
  - Terminal condition true: go to FINISH.
  - Otherwise, dreq=1 sampled: go to XFER.
- XFER: I=111, dack=1 for this cycle only; the beat counter increments (W bits).
  - Next state: FINISH if terminal; else XFER again if dreq=1 (back-to-back beats, one per cycle); else ACTIVE.
- Terminal condition:
  - Modes 0, 1, 3: done=1.
  - Mode 2: beat counter equals shadow count. A count of 0 means 2^W beats, because the counter wraps to 0.
  - In mode 2 the done input is ignored.
- FINISH: irq_done=1 for one cycle.
  - cfg_auto=0: go to IDLE (busy falls the following cycle).
  - cfg_auto=1: go to REIN.
- REIN: I=100 for one cycle; the beat counter clears; go to ACTIVE. The WRCR/LDAD/LDWC sequence is not repeated.
- abort=1 in any non-IDLE state:
  - Next state is IDLE and aborted pulses for one cycle; dack/data_oe are not asserted that cycle; irq_done is not asserted.
  - abort together with terminal in XFER: abort wins.
- start while not IDLE is ignored. start and abort together in IDLE: abort is ignored and start is accepted.
- Asynchronous reset mid-transfer: all outputs return to reset values immediately, independent of clk.
- data_oe=1 only in WRCR/LDAD/LDWC, so the sequencer never drives DATA while a read instruction is issued.

Test Plan:
- Mode 0 setup: W=8, cfg_cr=000, addr=8'h40, count=8'h03, start -> I sequence 000,101,110 with data_out 00,40,03 and data_oe=1 for those 3 cycles, then I=001.
- Mode 0 beats: dreq held high, done asserted with the 3rd ENCT -> exactly 3 back-to-back cycles of I=111/dack=1, then one-cycle irq_done, then busy=0.
- Mode 2 count: cfg_cr=010, count=5, done tied high, dreq toggled every other cycle -> exactly 5 dack pulses, each separated by one ACTIVE cycle, then irq_done.
- Autoload: cfg_auto=1, mode 1, done after 2 beats -> irq_done, then I=100 for one cycle, then ACTIVE; further dreq produces ENCT with no WRCR/LDAD/LDWC.
- Abort: abort during the 2nd XFER of a 4-beat transfer -> next cycle IDLE with aborted=1, irq_done=0, dack=0; a later start performs a full setup.
- Reset: rst_n low mid-XFER, asynchronous to clk -> I=001, dack=0, busy=0 immediately; start ignored while rst_n=0.

Source files
------------

// File: rtl/am2940_dma_sequencer.sv
// Am2940 DMA sequencer.
// Drives the instruction lines I[2:0] and DATA-bus write values of an Am2940
// address generator. For each transfer it writes the control register, loads
// the address and the word count, then issues one ENCT per beat under a
// DREQ/DACK handshake. At end of transfer it pulses irq_done and either goes
// idle or re-initialises the generator (autoload).
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start, abort      transfer request (IDLE only) / transfer termination
//   cfg_cr/addr/count/auto  configuration, captured on an accepted start
//   dreq, done        peripheral beat request, generator terminal-count flag
//   I                 instruction to address generator / decoder
//   data_out, data_oe DATA-bus value and drive enable
//   dack              beat acknowledge, one cycle per ENCT
//   busy              high whenever not idle
//   irq_done, aborted one-cycle completion / abort pulses
module am2940_dma_sequencer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         abort,
  input  logic [2:0]   cfg_cr,
  input  logic [W-1:0] cfg_addr,
  input  logic [W-1:0] cfg_count,
  input  logic         cfg_auto,
  input  logic         dreq,
  input  logic         done,
  output logic [2:0]   I,
  output logic [W-1:0] data_out,
  output logic         data_oe,
  output logic         dack,
  output logic         busy,
  output logic         irq_done,
  output logic         aborted
);

  typedef enum logic [2:0] {
    S_IDLE, S_WRCR, S_LDAD, S_LDWC, S_ACTIVE, S_XFER, S_FINISH, S_REIN
  } state_t;

  localparam logic [2:0] I_WRCR = 3'b000;
  localparam logic [2:0] I_RDCR = 3'b001;
  localparam logic [2:0] I_LDAD = 3'b101;
  localparam logic [2:0] I_LDWC = 3'b110;
  localparam logic [2:0] I_REIN = 3'b100;
  localparam logic [2:0] I_ENCT = 3'b111;

  state_t       state, state_nxt;
  logic [2:0]   cr_sh;
  logic [W-1:0] addr_sh, count_sh;
  logic         auto_sh;
  logic [W-1:0] beat_cnt, beat_inc;
  logic         mode2, term_active, term_xfer;

  logic [2:0]   i_nxt;
  logic [W-1:0] data_nxt;
  logic         oe_nxt, dack_nxt, busy_nxt, irq_nxt, abt_nxt;

  assign beat_inc = beat_cnt + 1'b1;
  assign mode2    = (cr_sh[1:0] == 2'b10);

  // In mode 2 the last beat always ends in XFER, so the count comparison uses
  // the post-increment value there. A count of 0 wraps after 2^W beats.
  // The ACTIVE comparison can only match a non-zero counter, so an initial
  // counter of 0 against a count of 0 is not taken as terminal.
  assign term_xfer   = mode2 ? (beat_inc == count_sh) : done;
  assign term_active = mode2 ? ((beat_cnt == count_sh) && (beat_cnt != '0)) : done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      I        <= I_RDCR;
      data_out <= '0;
      data_oe  <= 1'b0;
      dack     <= 1'b0;
      busy     <= 1'b0;
      irq_done <= 1'b0;
      aborted  <= 1'b0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      I        <= i_nxt;
      data_out <= data_nxt;
      data_oe  <= oe_nxt;
      dack     <= dack_nxt;
      busy     <= busy_nxt;
      irq_done <= irq_nxt;
      aborted  <= abt_nxt;
      if ((state == S_IDLE && start) || state == S_REIN) begin
        beat_cnt <= '0;
      end else if (state == S_XFER) begin
        beat_cnt <= beat_inc;
      end
    end
  end

  // Configuration shadows hold data only; they are valid from the accepted
  // start onwards, so they need no reset.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && start) begin
      cr_sh    <= cfg_cr;
      addr_sh  <= cfg_addr;
      count_sh <= cfg_count;
      auto_sh  <= cfg_auto;
    end
  end

  always_comb begin
    state_nxt = state;
    abt_nxt   = 1'b0;
    if (state == S_IDLE) begin
      if (start) state_nxt = S_WRCR;
    end else if (abort) begin
      state_nxt = S_IDLE;
      abt_nxt   = 1'b1;
    end else begin
      case (state)
        S_WRCR:   state_nxt = S_LDAD;
        S_LDAD:   state_nxt = S_LDWC;
        S_LDWC:   state_nxt = S_ACTIVE;
        S_ACTIVE: state_nxt = term_active ? S_FINISH : (dreq ? S_XFER : S_ACTIVE);
        S_XFER:   state_nxt = term_xfer ? S_FINISH : (dreq ? S_XFER : S_ACTIVE);
        S_FINISH: state_nxt = auto_sh ? S_REIN : S_IDLE;
        S_REIN:   state_nxt = S_ACTIVE;
        default:  state_nxt = S_IDLE;
      endcase
    end

    // Outputs are registered: decode them from the state being entered.
    i_nxt    = I_RDCR;
    data_nxt = '0;
    oe_nxt   = 1'b0;
    dack_nxt = 1'b0;
    irq_nxt  = 1'b0;
    busy_nxt = (state_nxt != S_IDLE);
    case (state_nxt)
      S_WRCR: begin
        // Shadow CR loads on this same edge, so take the value being captured.
        i_nxt         = I_WRCR;
        data_nxt[2:0] = cfg_cr;
        oe_nxt        = 1'b1;
      end
      S_LDAD: begin
        i_nxt    = I_LDAD;
        data_nxt = addr_sh;
        oe_nxt   = 1'b1;
      end
      S_LDWC: begin
        i_nxt    = I_LDWC;
        data_nxt = count_sh;
        oe_nxt   = 1'b1;
      end
      S_XFER: begin
        i_nxt    = I_ENCT;
        dack_nxt = 1'b1;
      end
      S_FINISH: irq_nxt = 1'b1;
      S_REIN:   i_nxt   = I_REIN;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_am2940_dma_sequencer.sv
module tb_am2940_dma_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0, abort = 1'b0, cfg_auto = 1'b0, dreq = 1'b0, done = 1'b0;
  logic [2:0] cfg_cr = 3'b000;
  logic [7:0] cfg_addr = 8'h00, cfg_count = 8'h00;
  logic [2:0] I;
  logic [7:0] data_out;
  logic       data_oe, dack, busy, irq_done, aborted;

  int n_chk = 0;
  int n_fail = 0;

  am2940_dma_sequencer #(.W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_cr(cfg_cr), .cfg_addr(cfg_addr), .cfg_count(cfg_count), .cfg_auto(cfg_auto),
    .dreq(dreq), .done(done), .I(I), .data_out(data_out), .data_oe(data_oe),
    .dack(dack), .busy(busy), .irq_done(irq_done), .aborted(aborted)
  );

  always #5 clk = ~clk;

  // Transaction-level reference: a transfer is running, possibly in one of
  // the three setup steps, on a beat, completing, or reloading; otherwise it
  // is waiting for a beat request.
  bit         m_run, m_beat, m_fin, m_rein, m_abt, m_auto;
  int         m_setup;   // -1 when not in setup, else index 0..2
  int         m_nb;      // beats since start / reload (not wrapped)
  logic [2:0] m_cr;
  logic [7:0] m_addr, m_cnt;

  function automatic void model_reset();
    m_run = 0; m_beat = 0; m_fin = 0; m_rein = 0; m_abt = 0; m_setup = -1; m_nb = 0;
  endfunction

  function automatic bit model_term(int nb);
    int target;
    if (m_cr[1:0] == 2'b10) begin
      target = (m_cnt == 0) ? 256 : int'(m_cnt);
      return nb == target;
    end
    return done;
  endfunction

  function automatic void model_step();
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_abt = 0;
    if (!m_run) begin
      if (start) begin
        m_cr = cfg_cr; m_addr = cfg_addr; m_cnt = cfg_count; m_auto = cfg_auto;
        m_run = 1; m_setup = 0; m_nb = 0;
      end
    end else if (abort) begin
      model_reset();
      m_abt = 1;
    end else if (m_setup >= 0) begin
      m_setup = (m_setup == 2) ? -1 : m_setup + 1;
    end else if (m_beat) begin
      m_nb++;
      if (model_term(m_nb)) begin
        m_beat = 0; m_fin = 1;
      end else begin
        m_beat = dreq;
      end
    end else if (m_fin) begin
      m_fin = 0;
      if (m_auto) m_rein = 1; else m_run = 0;
    end else if (m_rein) begin
      m_rein = 0; m_nb = 0;
    end else begin
      if (model_term(m_nb)) m_fin = 1;
      else if (dreq) m_beat = 1;
    end
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    int ei, ed;
    ei = 1; ed = 0;
    if (m_setup == 0) begin ei = 0; ed = int'(m_cr); end
    else if (m_setup == 1) begin ei = 5; ed = int'(m_addr); end
    else if (m_setup == 2) begin ei = 6; ed = int'(m_cnt); end
    else if (m_beat) ei = 7;
    else if (m_rein) ei = 4;
    chk("I", int'(I), ei);
    chk("data_out", int'(data_out), ed);
    chk("data_oe", int'(data_oe), int'(m_setup >= 0));
    chk("dack", int'(dack), int'(m_beat));
    chk("busy", int'(busy), int'(m_run));
    chk("irq_done", int'(irq_done), int'(m_fin));
    chk("aborted", int'(aborted), int'(m_abt));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic setup3();
    start = 1'b1;
    cycle();
    start = 1'b0;
    cycle();
    cycle();
  endtask

  initial begin
    int nd, ni;
    bit seen;
    model_reset();
    m_cr = 0; m_addr = 0; m_cnt = 0; m_auto = 0;

    // reset
    #2 rst_n = 1'b0;
    cycle();
    cycle();
    chk("rst I", int'(I), 1);
    chk("rst busy", int'(busy), 0);
    chk("rst data_oe", int'(data_oe), 0);
    rst_n = 1'b1;
    cycle();

    // mode 0 setup and beats
    cfg_cr = 3'b000; cfg_addr = 8'h40; cfg_count = 8'h03; cfg_auto = 1'b0;
    start = 1'b1;
    cycle();
    start = 1'b0; cfg_addr = 8'hFF; cfg_count = 8'h77; cfg_cr = 3'b111;
    chk("m0 wrcr I", int'(I), 0);
    chk("m0 wrcr data", int'(data_out), 8'h00);
    chk("m0 wrcr oe", int'(data_oe), 1);
    cycle();
    chk("m0 ldad I", int'(I), 5);
    chk("m0 ldad data", int'(data_out), 8'h40);
    cycle();
    chk("m0 ldwc I", int'(I), 6);
    chk("m0 ldwc data", int'(data_out), 8'h03);
    dreq = 1'b1;
    cycle();
    chk("m0 active I", int'(I), 1);
    chk("m0 active oe", int'(data_oe), 0);
    cycle();
    chk("m0 x1 dack", int'(dack), 1);
    cycle();
    chk("m0 x2 I", int'(I), 7);
    cycle();
    chk("m0 x3 dack", int'(dack), 1);
    done = 1'b1; dreq = 1'b0;
    cycle();
    chk("m0 fin irq", int'(irq_done), 1);
    chk("m0 fin dack", int'(dack), 0);
    done = 1'b0;
    cycle();
    chk("m0 idle busy", int'(busy), 0);

    // mode 2 count 5, done ignored, dreq toggling
    cfg_cr = 3'b010; cfg_count = 8'd5; cfg_addr = 8'h12; done = 1'b1;
    setup3();
    dreq = 1'b0; nd = 0; ni = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (dack) nd++;
      if (irq_done) ni++;
      dreq = ~dreq;
    end
    chk("m2 dack pulses", nd, 5);
    chk("m2 irq pulses", ni, 1);
    done = 1'b0; dreq = 1'b0;
    cycle();

    // autoload, mode 1
    cfg_cr = 3'b001; cfg_count = 8'd9; cfg_auto = 1'b1;
    setup3();
    dreq = 1'b1;
    cycle();
    cycle();
    chk("al x1 dack", int'(dack), 1);
    cycle();
    done = 1'b1; dreq = 1'b0;
    cycle();
    chk("al fin irq", int'(irq_done), 1);
    done = 1'b0;
    cycle();
    chk("al rein I", int'(I), 4);
    cycle();
    chk("al active I", int'(I), 1);
    chk("al active oe", int'(data_oe), 0);
    dreq = 1'b1;
    cycle();
    chk("al enct I", int'(I), 7);
    dreq = 1'b0; abort = 1'b1;
    cycle();
    chk("al abort pulse", int'(aborted), 1);
    abort = 1'b0; cfg_auto = 1'b0;
    cycle();

    // abort during 2nd beat of a 4-beat transfer
    cfg_cr = 3'b010; cfg_count = 8'd4;
    setup3();
    dreq = 1'b1;
    cycle();
    cycle();
    cycle();
    chk("ab x2 dack", int'(dack), 1);
    abort = 1'b1;
    cycle();
    chk("ab aborted", int'(aborted), 1);
    chk("ab irq", int'(irq_done), 0);
    chk("ab dack", int'(dack), 0);
    chk("ab busy", int'(busy), 0);
    abort = 1'b0; dreq = 1'b0; start = 1'b1;
    cycle();
    start = 1'b0;
    chk("ab restart I", int'(I), 0);
    cycle();
    chk("ab restart ldad", int'(I), 5);
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    cycle();

    // mode 2, count 0 means 256 beats
    cfg_cr = 3'b010; cfg_count = 8'd0;
    setup3();
    dreq = 1'b1; nd = 0; seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      cycle();
      if (dack) nd++;
      if (irq_done) seen = 1;
    end
    chk("c0 beats", nd, 256);
    chk("c0 irq seen", int'(seen), 1);
    dreq = 1'b0;
    cycle();
    cycle();

    // asynchronous reset mid-XFER
    cfg_cr = 3'b000; cfg_count = 8'd7;
    setup3();
    dreq = 1'b1;
    cycle();
    cycle();
    chk("rs pre dack", int'(dack), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rs async I", int'(I), 1);
    chk("rs async dack", int'(dack), 0);
    chk("rs async busy", int'(busy), 0);
    model_reset();
    start = 1'b1;
    cycle();
    cycle();
    chk("rs start ignored", int'(busy), 0);
    start = 1'b0; dreq = 1'b0;
    rst_n = 1'b1;
    cycle();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      start     = ($urandom_range(0, 7) == 0);
      abort     = ($urandom_range(0, 39) == 0);
      dreq      = $urandom_range(0, 1);
      done      = ($urandom_range(0, 15) == 0);
      cfg_cr    = 3'($urandom_range(0, 7));
      cfg_addr  = 8'($urandom_range(0, 255));
      cfg_count = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 12));
      cfg_auto  = $urandom_range(0, 1);
      cycle();
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
